// File: rtl/if_id_fetch_stage.sv
// Instruction fetch plus IF/ID register; optional stall/flush counters under `ifdef FETCH_PERF_EN.
// Latency: the word fetched at pc_o appears on if_id_instr_o one edge later; a redirect costs one bubble.
// Backpressure: stall_i holds PC and IF/ID indefinitely, and flush_i takes priority over stall_i.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic [4:0]  if_id_rs_o,
    output logic [4:0]  if_id_rt_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] w_pc_next;

    // Modulo-2^32 add: 32'hFFFF_FFFC steps to zero.
    assign w_pc_next = r_pc + PC_STEP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_instr <= NOP_INSTR;
                    r_pc4   <= 32'd0;
                    r_valid <= 1'b0;
                    if (start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        // PC and IF/ID hold on the leaving edge; IDLE bubbles from the next one.
                        r_state <= ST_IDLE;
                    end else if (flush_i) begin
                        r_pc    <= target_i;
                        r_instr <= NOP_INSTR;
                        r_pc4   <= 32'd0;
                        r_valid <= 1'b0;
                    end else if (!stall_i) begin
                        r_pc    <= w_pc_next;
                        r_instr <= imem_data_i;
                        r_pc4   <= w_pc_next;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_run_edge;

    assign w_run_edge = (r_state == ST_RUN) && start_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else if (w_run_edge) begin
            if (flush_i) begin
                if (r_flush_cnt != 16'hFFFF) begin
                    r_flush_cnt <= r_flush_cnt + 16'd1;
                end
            end else if (stall_i) begin
                if (r_stall_cnt != 16'hFFFF) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    assign pc_o          = r_pc;
    assign imem_addr_o   = r_pc;
    assign if_id_instr_o = r_instr;
    assign if_id_pc4_o   = r_pc4;
    assign if_id_valid_o = r_valid;
    assign if_id_rs_o    = r_instr[25:21];
    assign if_id_rt_o    = r_instr[20:16];

endmodule
